// File: rtl/vec_cache_us_rdata_egress_pkg.sv
// Shared types and constants for the upstream read-data egress path.
// Line payloads arrive whole and leave as US_BEAT_NUM beats.
package vec_cache_us_rdata_egress_pkg;

  localparam int unsigned DATA_WIDTH  = 1024;
  localparam int unsigned TXNID_W     = 8;
  localparam int unsigned ROB_ID_W    = 6;
  localparam int unsigned SIDEBAND_W  = 4;

  localparam int unsigned US_BEAT_NUM            = 4;
  localparam int unsigned US_EGRESS_DEPTH        = 4;
  localparam int unsigned US_EGRESS_NFULL_THRESH = 2;

  localparam int unsigned US_BEAT_W     = DATA_WIDTH / US_BEAT_NUM;
  localparam int unsigned US_BEAT_IDX_W = (US_BEAT_NUM > 1) ? $clog2(US_BEAT_NUM) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TXNID_W-1:0]    txnid;
    logic [ROB_ID_W-1:0]   rob_entry_id;
    logic [SIDEBAND_W-1:0] sideband;
  } us_data_pld_t;

  typedef struct packed {
    logic [US_BEAT_W-1:0]     data;
    logic [TXNID_W-1:0]       txnid;
    logic [ROB_ID_W-1:0]      rob_entry_id;
    logic [SIDEBAND_W-1:0]    sideband;
    logic [US_BEAT_IDX_W-1:0] beat_idx;
    logic                     last;
  } us_beat_pld_t;

  // Counter width that stays at least one bit for single-value ranges.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_cache_sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head read.
// The caller is responsible for never pushing into a full FIFO without a pop.
module vec_cache_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       full_o
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CNTW'(DEPTH));

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNTW'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop_i |-> cnt_q != '0);

endmodule

// File: rtl/vec_cache_us_rdata_egress.sv
// Buffers full-line read responses and serializes each into BEAT_NUM beats
// on the US valid/ready channel; flags overflow and near-full occupancy.
module vec_cache_us_rdata_egress
  import vec_cache_us_rdata_egress_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = US_EGRESS_DEPTH,
  parameter int unsigned BEAT_NUM     = US_BEAT_NUM,
  parameter int unsigned NFULL_THRESH = US_EGRESS_NFULL_THRESH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdb_to_us_data_vld,
  input  us_data_pld_t rdb_to_us_data_pld,
  output logic         us_rdata_vld,
  output us_beat_pld_t us_rdata_pld,
  input  logic         us_rdata_rdy,
  output logic         egress_nfull,
  output logic         egress_ovf_err
);

  localparam int unsigned CNTW  = $clog2(FIFO_DEPTH+1);
  localparam int unsigned BCW   = min1_clog2(BEAT_NUM);
  localparam int unsigned BW    = DATA_WIDTH / BEAT_NUM;
  localparam int unsigned PLD_W = $bits(us_data_pld_t);

  logic [CNTW-1:0]  cnt;
  logic             full;
  logic [PLD_W-1:0] head_raw;
  us_data_pld_t     head;
  logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
  logic             ovf_q, ovf_d;
  logic             hs, last_beat, pop, push;
  logic [BW-1:0]    slice;
  logic [CNTW-1:0]  free_cnt;

  assign us_rdata_vld = (cnt != '0);
  assign last_beat    = (beat_cnt_q == BCW'(BEAT_NUM-1));
  assign hs           = us_rdata_vld & us_rdata_rdy;
  assign pop          = hs & last_beat;
  // A full FIFO still takes a line when the head retires in the same cycle.
  assign push         = rdb_to_us_data_vld & (~full | pop);

  vec_cache_sync_fifo #(
    .WIDTH (PLD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_line_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (rdb_to_us_data_pld),
    .rdata_o (head_raw),
    .cnt_o   (cnt),
    .full_o  (full)
  );

  assign head = us_data_pld_t'(head_raw);

  always_comb begin
    slice = '0;
    for (int unsigned k = 0; k < BEAT_NUM; k++) begin
      if (beat_cnt_q == BCW'(k)) slice = head.data[k*BW +: BW];
    end
  end

  always_comb begin
    us_rdata_pld              = '0;
    us_rdata_pld.data         = slice;
    us_rdata_pld.txnid        = head.txnid;
    us_rdata_pld.rob_entry_id = head.rob_entry_id;
    us_rdata_pld.sideband     = head.sideband;
    us_rdata_pld.beat_idx     = US_BEAT_IDX_W'(beat_cnt_q);
    us_rdata_pld.last         = last_beat;
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (hs) beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
    ovf_d = ovf_q | (rdb_to_us_data_vld & full & ~pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign free_cnt       = CNTW'(FIFO_DEPTH) - cnt;
  assign egress_nfull   = (free_cnt >= CNTW'(NFULL_THRESH));
  assign egress_ovf_err = ovf_q;

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (us_rdata_vld && !us_rdata_rdy) |=> (us_rdata_vld && $stable(us_rdata_pld)));

endmodule

// File: tb/tb_vec_cache_us_rdata_egress.sv
// Directed and randomised bench for the US read-data egress stage with a
// line-queue reference model checked on every falling clock edge.
module tb_vec_cache_us_rdata_egress;
  import vec_cache_us_rdata_egress_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned THRESH = 2;
  localparam int unsigned BW     = DATA_WIDTH / BEATS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_vld;
  us_data_pld_t in_pld;
  logic         vld;
  us_beat_pld_t pld;
  logic         rdy;
  logic         nfull;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  us_data_pld_t mq[$];
  int           mbeat = 0;
  logic         movf  = 1'b0;
  logic         prev_stall = 1'b0;
  us_beat_pld_t prev_pld;

  vec_cache_us_rdata_egress #(
    .FIFO_DEPTH   (DEPTH),
    .BEAT_NUM     (BEATS),
    .NFULL_THRESH (THRESH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rdb_to_us_data_vld (in_vld),
    .rdb_to_us_data_pld (in_pld),
    .us_rdata_vld       (vld),
    .us_rdata_pld       (pld),
    .us_rdata_rdy       (rdy),
    .egress_nfull       (nfull),
    .egress_ovf_err     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic us_data_pld_t mk(input int unsigned i);
    us_data_pld_t p;
    for (int unsigned w = 0; w < DATA_WIDTH/32; w++)
      p.data[w*32 +: 32] = 32'hC0DE_0000 | ((i & 32'hFF) << 8) | w;
    p.txnid        = 8'(i + 16);
    p.rob_entry_id = 6'(i);
    p.sideband     = 4'(i);
    return p;
  endfunction

  function automatic us_data_pld_t rnd_line();
    us_data_pld_t p;
    for (int unsigned w = 0; w < DATA_WIDTH/32; w++) p.data[w*32 +: 32] = $urandom;
    p.txnid        = 8'($urandom);
    p.rob_entry_id = 6'($urandom);
    p.sideband     = 4'($urandom);
    return p;
  endfunction

  // Reference model: queue of whole lines, current beat index, sticky overflow.
  always @(negedge clk) begin
    us_data_pld_t hl;
    logic         exp_vld;
    logic         do_pop;
    if (!rst_n) begin
      chk("rst_vld", 512'(vld), 512'(1'b0));
      chk("rst_nfull", 512'(nfull), 512'(1'b1));
      chk("rst_ovf", 512'(ovf), 512'(1'b0));
      chk("rst_beat_idx", 512'(pld.beat_idx), 512'(0));
      chk("rst_last", 512'(pld.last), 512'(1'b0));
      mq.delete();
      mbeat      = 0;
      movf       = 1'b0;
      prev_stall = 1'b0;
    end else begin
      exp_vld = (mq.size() != 0);
      chk("vld", 512'(vld), 512'(exp_vld));
      chk("nfull", 512'(nfull), 512'((DEPTH - mq.size()) >= THRESH));
      chk("ovf", 512'(ovf), 512'(movf));
      if (exp_vld) begin
        hl = mq[0];
        chk("data", 512'(pld.data), 512'(hl.data[mbeat*BW +: BW]));
        chk("txnid", 512'(pld.txnid), 512'(hl.txnid));
        chk("rob_id", 512'(pld.rob_entry_id), 512'(hl.rob_entry_id));
        chk("sideband", 512'(pld.sideband), 512'(hl.sideband));
        chk("beat_idx", 512'(pld.beat_idx), 512'(mbeat));
        chk("last", 512'(pld.last), 512'(mbeat == int'(BEATS) - 1));
      end
      if (prev_stall) begin
        chk("stall_vld", 512'(vld), 512'(1'b1));
        chk("stall_pld", 512'(pld), 512'(prev_pld));
      end
      prev_stall = vld && !rdy;
      prev_pld   = pld;
      do_pop = 1'b0;
      if (exp_vld && rdy) begin
        if (mbeat == int'(BEATS) - 1) begin
          do_pop = 1'b1;
          mbeat  = 0;
        end else begin
          mbeat++;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (in_vld) begin
        if (mq.size() < DEPTH) mq.push_back(in_pld);
        else movf = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    rdy = 1'b1;
    while ((mq.size() != 0 || vld) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 512'(n < budget), 512'(1'b1));
  endtask

  initial begin
    logic [BW-1:0] exp_slice [4];
    us_data_pld_t  l1, l8;
    int unsigned   pushed, guard;

    exp_slice[0] = {32{8'h11}};
    exp_slice[1] = {32{8'h22}};
    exp_slice[2] = {32{8'h33}};
    exp_slice[3] = {32{8'h44}};

    rst_n  = 1'b0;
    in_vld = 1'b0;
    in_pld = '0;
    rdy    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("lit_reset_vld", 512'(vld), 512'(1'b0));
    chk("lit_reset_nfull", 512'(nfull), 512'(1'b1));
    chk("lit_reset_ovf", 512'(ovf), 512'(1'b0));

    // Single line, ready held high: four beats in slice order.
    l1.data         = {exp_slice[3], exp_slice[2], exp_slice[1], exp_slice[0]};
    l1.txnid        = 8'h5A;
    l1.rob_entry_id = 6'h15;
    l1.sideband     = 4'h9;
    rdy    = 1'b1;
    in_vld = 1'b1;
    in_pld = l1;
    step();
    in_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("lit_s1_vld", 512'(vld), 512'(1'b1));
      chk("lit_s1_data", 512'(pld.data), 512'(exp_slice[k]));
      chk("lit_s1_beat_idx", 512'(pld.beat_idx), 512'(k));
      chk("lit_s1_last", 512'(pld.last), 512'(k == 3));
      chk("lit_s1_txnid", 512'(pld.txnid), 512'(8'h5A));
      chk("lit_s1_rob", 512'(pld.rob_entry_id), 512'(6'h15));
      step();
    end
    chk("lit_s1_idle", 512'(vld), 512'(1'b0));

    // Fill with ready low.
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1;
      in_pld = mk(i);
      step();
      if (i == 1) chk("lit_nfull_2", 512'(nfull), 512'(1'b1));
      if (i == 2) chk("lit_nfull_3", 512'(nfull), 512'(1'b0));
    end
    in_vld = 1'b0;
    repeat (20) step();
    chk("lit_hold_vld", 512'(vld), 512'(1'b1));
    chk("lit_hold_beat", 512'(pld.beat_idx), 512'(0));
    chk("lit_hold_txnid", 512'(pld.txnid), 512'(8'd16));

    // Push coincident with last-beat handshake while full.
    rdy = 1'b1;
    repeat (3) step();
    chk("lit_coinc_last", 512'(pld.last), 512'(1'b1));
    in_vld = 1'b1;
    in_pld = mk(4);
    step();
    in_vld = 1'b0;
    chk("lit_coinc_ovf", 512'(ovf), 512'(1'b0));
    chk("lit_coinc_nfull", 512'(nfull), 512'(1'b0));
    chk("lit_coinc_next", 512'(pld.txnid), 512'(8'd17));

    // Push into a full FIFO with no pop: dropped, sticky error.
    rdy    = 1'b0;
    in_vld = 1'b1;
    in_pld = mk(5);
    step();
    in_vld = 1'b0;
    chk("lit_ovf_set", 512'(ovf), 512'(1'b1));
    repeat (3) step();
    chk("lit_ovf_sticky", 512'(ovf), 512'(1'b1));
    drain(200);

    // Random lines with random ready.
    pushed = 0;
    guard  = 0;
    while (pushed < 100 && guard < 5000) begin
      in_vld = ($urandom_range(0, 7) == 0);
      in_pld = rnd_line();
      if (in_vld) pushed++;
      rdy = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    in_vld = 1'b0;
    chk("rand_pushed", 512'(pushed), 512'(100));
    drain(1000);

    // Reset in the middle of a line.
    chk("lit_pre_rst_ovf", 512'(ovf), 512'(1'b1));
    rdy    = 1'b1;
    in_vld = 1'b1;
    in_pld = mk(7);
    step();
    in_vld = 1'b0;
    step();
    step();
    chk("lit_mid_beat", 512'(pld.beat_idx), 512'(2));
    rst_n = 1'b0;
    #1;
    chk("lit_mrst_vld", 512'(vld), 512'(1'b0));
    chk("lit_mrst_beat", 512'(pld.beat_idx), 512'(0));
    chk("lit_mrst_nfull", 512'(nfull), 512'(1'b1));
    chk("lit_mrst_ovf", 512'(ovf), 512'(1'b0));
    step();
    rst_n  = 1'b1;
    l8     = mk(8);
    in_vld = 1'b1;
    in_pld = l8;
    step();
    in_vld = 1'b0;
    chk("lit_post_vld", 512'(vld), 512'(1'b1));
    chk("lit_post_beat", 512'(pld.beat_idx), 512'(0));
    chk("lit_post_txnid", 512'(pld.txnid), 512'(8'd24));
    drain(50);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
